// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH add/shift pairs produce the
// 2*WIDTH-bit product in {A,B}, signed (final-iteration subtract) or unsigned.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned EXT_W = WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   m, m_next;
    logic [WIDTH-1:0]   a_next, b_next;
    logic               x_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               mode, mode_next;
    logic [EXT_W-1:0]   ext_a, ext_m, sum, diff;
    logic               last_iter;

    // Operand extension: sign-extend in signed mode, zero-extend otherwise.
    assign ext_a     = mode ? {Aval[WIDTH-1], Aval} : {1'b0, Aval};
    assign ext_m     = mode ? {m[WIDTH-1], m} : {1'b0, m};
    assign sum       = ext_a + ext_m;
    assign diff      = ext_a - ext_m;
    assign last_iter = (cnt == LAST_ITER);

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        a_next     = Aval;
        b_next     = Bval;
        x_next     = X;
        m_next     = m;
        cnt_next   = cnt;
        mode_next  = mode;
        case (state)
            IDLE: begin
                if (ClearA_LoadB) begin
                    a_next = '0;
                    x_next = 1'b0;
                    b_next = S;
                end else if (Run) begin
                    a_next     = '0;
                    x_next     = 1'b0;
                    m_next     = S;
                    mode_next  = Signed_Mode;
                    cnt_next   = '0;
                    state_next = ADD;
                end
            end
            ADD: begin
                // The multiplier MSB carries negative weight in signed mode.
                if (Bval[0]) begin
                    if (last_iter && mode) begin
                        {x_next, a_next} = diff;
                    end else begin
                        {x_next, a_next} = sum;
                    end
                end
                state_next = SHIFT;
            end
            SHIFT: begin
                a_next = {X, Aval[WIDTH-1:1]};
                b_next = {Aval[0], Bval[WIDTH-1:1]};
                if (!mode) begin
                    x_next = 1'b0;
                end
                if (last_iter) begin
                    state_next = HOLD;
                end else begin
                    cnt_next   = CNT_W'(cnt + 1'b1);
                    state_next = ADD;
                end
            end
            HOLD: begin
                if (!Run) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and status registers; status flags follow the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            Aval  <= '0;
            Bval  <= '0;
            X     <= 1'b0;
            m     <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            Aval  <= a_next;
            Bval  <= b_next;
            X     <= x_next;
            m     <= m_next;
            cnt   <= cnt_next;
            mode  <= mode_next;
            Busy  <= (state_next == ADD) || (state_next == SHIFT);
            Done  <= (state_next == HOLD);
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: WIDTH 4/8/16 instances driven in lockstep,
// hand-computed WIDTH=8 vectors plus a multiplication reference model.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset, run, clear_load, signed_mode;
    logic [3:0]  s4,  a4,  b4;
    logic [7:0]  s8,  a8,  b8;
    logic [15:0] s16, a16, b16;
    logic        x4, x8, x16;
    logic        busy4, busy8, busy16, done4, done8, done16;
    logic [3:0]  mb4;
    logic [7:0]  mb8;
    logic [15:0] mb16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .Clk(clk), .Reset(reset), .Run(run), .ClearA_LoadB(clear_load),
        .Signed_Mode(signed_mode), .S(s4), .Aval(a4), .Bval(b4), .X(x4),
        .Busy(busy4), .Done(done4));

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(reset), .Run(run), .ClearA_LoadB(clear_load),
        .Signed_Mode(signed_mode), .S(s8), .Aval(a8), .Bval(b8), .X(x8),
        .Busy(busy8), .Done(done8));

    shift_add_multiplier #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(reset), .Run(run), .ClearA_LoadB(clear_load),
        .Signed_Mode(signed_mode), .S(s16), .Aval(a16), .Bval(b16), .X(x16),
        .Busy(busy16), .Done(done16));

    typedef struct {
        logic [7:0] b;
        logic [7:0] s;
        logic       sm;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ex;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference product of w-bit operands, truncated to 2*w bits.
    function automatic logic [31:0] prod(input int w, input logic [15:0] m,
                                         input logic [15:0] b, input logic sm);
        longint am, bm, p, mask;
        mask = (longint'(1) << w) - 1;
        am = longint'(m) & mask;
        bm = longint'(b) & mask;
        if (sm) begin
            if (am >= (longint'(1) << (w - 1))) am = am - (longint'(1) << w);
            if (bm >= (longint'(1) << (w - 1))) bm = bm - (longint'(1) << w);
        end
        p = (am * bm) & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    // Optional load of B, start, scramble S/mode, track latency, check product.
    task automatic do_op(input logic [15:0] bv, input logic [15:0] sv, input logic sm,
                         input int hold, input bit load);
        logic [31:0] e4, e8, e16;
        int bad4, bad8, bad16;
        bad4 = 0; bad8 = 0; bad16 = 0;
        if (load) begin
            clear_load = 1'b1;
            s4 = bv[3:0]; s8 = bv[7:0]; s16 = bv;
            @(negedge clk);
            clear_load = 1'b0;
            mb4 = bv[3:0]; mb8 = bv[7:0]; mb16 = bv;
        end
        e4  = prod(4,  16'(sv[3:0]), 16'(mb4), sm);
        e8  = prod(8,  16'(sv[7:0]), 16'(mb8), sm);
        e16 = prod(16, sv, mb16, sm);
        s4 = sv[3:0]; s8 = sv[7:0]; s16 = sv;
        signed_mode = sm;
        run = 1'b1;
        @(negedge clk);
        s4 = ~s4; s8 = ~s8; s16 = ~s16;
        signed_mode = ~sm;
        for (int n = 1; n <= hold; n++) begin
            @(negedge clk);
            if (busy4  !== (n < 8)  || done4  !== (n >= 8))  bad4++;
            if (busy8  !== (n < 16) || done8  !== (n >= 16)) bad8++;
            if (busy16 !== (n < 32) || done16 !== (n >= 32)) bad16++;
        end
        check("lat4",  64'(bad4),  64'd0);
        check("lat8",  64'(bad8),  64'd0);
        check("lat16", 64'(bad16), 64'd0);
        check("prod4",  64'({a4, b4}),   64'(e4[7:0]));
        check("prod8",  64'({a8, b8}),   64'(e8[15:0]));
        check("prod16", 64'({a16, b16}), 64'(e16));
        check("x4",  64'(x4),  64'(sm & e4[7]));
        check("x8",  64'(x8),  64'(sm & e8[15]));
        check("x16", 64'(x16), 64'(sm & e16[31]));
        run = 1'b0;
        @(negedge clk);
        check("idle_flags", 64'({done4, done8, done16, busy4, busy8, busy16}), 64'd0);
        mb4 = e4[3:0]; mb8 = e8[7:0]; mb16 = e16[15:0];
    endtask

    initial begin
        tbl[0] = '{b: 8'h03, s: 8'hFE, sm: 1'b1, ea: 8'hFF, eb: 8'hFA, ex: 1'b1};
        tbl[1] = '{b: 8'h03, s: 8'hFE, sm: 1'b0, ea: 8'h02, eb: 8'hFA, ex: 1'b0};
        tbl[2] = '{b: 8'h80, s: 8'h80, sm: 1'b1, ea: 8'h40, eb: 8'h00, ex: 1'b0};
        tbl[3] = '{b: 8'hFF, s: 8'hFF, sm: 1'b1, ea: 8'h00, eb: 8'h01, ex: 1'b0};
        tbl[4] = '{b: 8'hFF, s: 8'hFF, sm: 1'b0, ea: 8'hFE, eb: 8'h01, ex: 1'b0};
        tbl[5] = '{b: 8'h7F, s: 8'h80, sm: 1'b1, ea: 8'hC0, eb: 8'h80, ex: 1'b1};
        tbl[6] = '{b: 8'h00, s: 8'h5A, sm: 1'b1, ea: 8'h00, eb: 8'h00, ex: 1'b0};
        tbl[7] = '{b: 8'h0C, s: 8'h0A, sm: 1'b0, ea: 8'h00, eb: 8'h78, ex: 1'b0};

        reset = 1'b1; run = 1'b0; clear_load = 1'b0; signed_mode = 1'b0;
        s4 = '0; s8 = '0; s16 = '0;
        mb4 = '0; mb8 = '0; mb16 = '0;
        repeat (2) @(negedge clk);
        check("reset_regs8", 64'({a8, b8, x8}), 64'd0);
        check("reset_regs16", 64'({a16, b16, x16}), 64'd0);
        check("reset_flags", 64'({busy4, busy8, busy16, done4, done8, done16}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Hand vectors; Run held 40 cycles to confirm a single operation.
        for (int i = 0; i < 8; i++) begin
            do_op({tbl[i].s, tbl[i].b}, {tbl[i].b, tbl[i].s}, tbl[i].sm, 40, 1'b1);
            check($sformatf("vec%0d_a", i), 64'(a8), 64'(tbl[i].ea));
            check($sformatf("vec%0d_b", i), 64'(b8), 64'(tbl[i].eb));
            check($sformatf("vec%0d_x", i), 64'(x8), 64'(tbl[i].ex));
        end

        // Chained multiply: new S times previous low half 0x78.
        do_op(16'h0000, 16'h0003, 1'b0, 33, 1'b0);
        check("chain_a8", 64'(a8), 64'h01);
        check("chain_b8", 64'(b8), 64'h68);

        // Reset mid-operation.
        clear_load = 1'b1; s4 = 4'h7; s8 = 8'h55; s16 = 16'h1234;
        @(negedge clk);
        clear_load = 1'b0;
        s4 = 4'h3; s8 = 8'h33; s16 = 16'h0F0F; signed_mode = 1'b1; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy8", 64'(busy8), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_regs8", 64'({a8, b8, x8}), 64'd0);
        check("rst_mid_regs16", 64'({a16, b16, x16}), 64'd0);
        check("rst_mid_flags", 64'({busy4, busy8, busy16, done4, done8, done16}), 64'd0);
        reset = 1'b0;
        mb4 = '0; mb8 = '0; mb16 = '0;
        @(negedge clk);

        // Load has priority over Run in IDLE.
        clear_load = 1'b1; run = 1'b1;
        s4 = 4'hC; s8 = 8'h5C; s16 = 16'hA55C;
        repeat (2) @(negedge clk);
        check("prio_busy", 64'({busy4, busy8, busy16}), 64'd0);
        check("prio_b8", 64'(b8), 64'h5C);
        check("prio_a8", 64'({a8, x8}), 64'd0);
        clear_load = 1'b0; run = 1'b0;
        mb4 = 4'hC; mb8 = 8'h5C; mb16 = 16'hA55C;
        @(negedge clk);
        do_op(16'h0000, 16'h0002, 1'b0, 33, 1'b0);
        check("prio_chain_a8", 64'(a8), 64'h00);
        check("prio_chain_b8", 64'(b8), 64'hB8);

        // Exhaustive WIDTH=4; wider instances see random operands.
        for (int b = 0; b < 16; b++) begin
            for (int s = 0; s < 16; s++) begin
                for (int sm = 0; sm < 2; sm++) begin
                    logic [15:0] bv, sv;
                    bv = 16'($urandom); sv = 16'($urandom);
                    bv[3:0] = 4'(b); sv[3:0] = 4'(s);
                    do_op(bv, sv, 1'(sm), 33, 1'b1);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have ports, in order:
  Clk  input  1  sole clock, all state updates on rising edge
  Reset  input  1  synchronous, active-high reset
  Run  input  1  level; start request (sampled in IDLE)
  ClearA_LoadB  input  1  level; in IDLE, load B from S and clear A, X
  Signed_Mode  input  1  1 = two's-complement multiply, 0 = unsigned
  S  input  WIDTH  multiplicand / load value
  Aval  output  WIDTH  register A, product upper half
  Bval  output  WIDTH  register B, multiplier then product lower half
  X  output  1  sign/carry extension bit of A
  Busy  output  1  high in ADD and SHIFT states
  Done  output  1  high in HOLD state
REQ-003 SHALL use one clock; reset is synchronous and active-high (Clk, Reset).

Function
REQ-004 SHALL implement states IDLE, ADD, SHIFT, HOLD plus an iteration counter of ceil(log2(WIDTH)) bits; no per-iteration enumerated states.
REQ-005 IDLE: ClearA_LoadB=1 -> A<=0, X<=0, B<=S, remain IDLE; ClearA_LoadB has priority over Run on the same edge.
REQ-006 IDLE: Run=1, ClearA_LoadB=0 -> A<=0, X<=0, S latched into internal multiplicand M, Signed_Mode latched, counter<=0, go to ADD; B retained.
REQ-007 S and Signed_Mode changes after the start edge SHALL NOT affect the running operation.
REQ-008 ADD (one cycle): if B[0]=0, A and X unchanged; if B[0]=1 and counter<WIDTH-1, {X,A} <= ext(A)+ext(M); if B[0]=1, counter=WIDTH-1 and signed, {X,A} <= ext(A)-ext(M); unsigned last iteration adds; go to SHIFT.
REQ-009 ext() SHALL be sign extension to WIDTH+1 bits in signed mode, zero extension in unsigned mode; result truncated to WIDTH+1 bits.
REQ-010 SHIFT (one cycle): A <= {X, A[WIDTH-1:1]}, B <= {A[0], B[WIDTH-1:1]}; X unchanged in signed mode, X <= 0 in unsigned mode.
REQ-011 SHIFT with counter=WIDTH-1 -> HOLD; otherwise counter++ and -> ADD.
REQ-012 Latency: start edge at cycle k; WIDTH add/shift pairs on edges k+1..k+2*WIDTH; Done=1 from the cycle after edge k+2*WIDTH.
REQ-013 Result: {A,B} SHALL equal the exact 2*WIDTH-bit product (signed or unsigned per latched mode) in HOLD; X equals A[WIDTH-1] in signed mode, 0 in unsigned mode.
REQ-014 HOLD: registers frozen; stay while Run=1; Run=0 -> IDLE. No retrigger without Run returning low.
REQ-015 Run and ClearA_LoadB SHALL be ignored in ADD, SHIFT, HOLD (except REQ-014 exit).
REQ-016 A new start from IDLE SHALL multiply the new S by current B (chained multiply of previous low half).
REQ-017 Busy and Done SHALL be Moore outputs decoded from state only; never both high.

Reset
REQ-018 Reset=1 on a rising edge SHALL force IDLE, A=0, B=0, X=0, M=0, counter=0, latched mode=0, Busy=0, Done=0, regardless of state, including mid-operation.
REQ-019 Reset SHALL have priority over all other inputs; first operation after Reset deassertion is governed by REQ-005/006.

Verification
REQ-020 WIDTH=8 signed: load B=0x03, S=0xFE, Run -> after 16 cycles Done=1, A=0xFF, B=0xFA, X=1 (-6).
REQ-021 WIDTH=8 unsigned: B=0x03, S=0xFE -> A=0x02, B=0xFA, X=0 (762); signed 0x80*0x80 -> A=0x40, B=0x00, X=0; signed 0xFF*0xFF -> A=0x00, B=0x01.
REQ-022 Run held high 40 cycles -> exactly one operation, Done stays 1; Run low -> IDLE next cycle, Done=0.
REQ-023 Reset asserted at cycle 5 of an operation -> next cycle IDLE, A=B=X=0, Busy=0; S toggled mid-operation -> result unchanged.
REQ-024 ClearA_LoadB and Run both high in IDLE -> load only, Busy stays 0; WIDTH=4 and WIDTH=16 exhaustive/random products match a reference model, latency 2*WIDTH.
